msx_bus_initiator: RTL and testbench

//  Host-side (initiator) end of the MSX cartridge bus. It turns a single request/ack

---
 rtl/msx_bus_initiator.sv | 217 +++++++++++++++++++++
 tb/tb_msx_bus_initiator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/msx_bus_initiator.sv
// Host-side MSX cartridge bus initiator: one REQ/ACK transaction becomes a Z80-timed memory
// or I/O cycle. Optional wait abort is enabled with `define MSX_BUS_INITIATOR_WAIT_TIMEOUT_EN.
module msx_bus_initiator #(
    parameter int unsigned T_DIV        = 6,
    parameter int unsigned WAIT_TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        REQ,
    input  logic        REQ_WR,
    input  logic        REQ_IO,
    input  logic [15:0] REQ_ADDR,
    input  logic [7:0]  REQ_WDATA,
    output logic        ACK,
    output logic [7:0]  RDATA,
    output logic        BUSY,
    output logic        TIMEOUT_ERR,
    output logic [15:0] ADDR,
    output logic [7:0]  DOUT,
    output logic        DOUT_OE,
    input  logic [7:0]  DIN,
    input  logic        BUSDIR_n,
    input  logic        WAIT_n,
    output logic        MERQ_n,
    output logic        IORQ_n,
    output logic        RD_n,
    output logic        WR_n,
    output logic        SLTSL_n
);

    localparam int unsigned CW = (T_DIV > 2) ? $clog2(T_DIV) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(T_DIV - 1);
    localparam logic [CW-1:0] T_HALF = CW'(T_DIV / 2);

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StTw,
        StT3,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          wr_q, wr_d;
    logic          io_q, io_d;
    logic          owed_q, owed_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;

    logic t_last;
    logic accept;
    logic wait_expired;
    logic timed_out;

    assign t_last = (tcnt_q == T_LAST);
    assign accept = (state_q == StIdle) && REQ;

`ifdef MSX_BUS_INITIATOR_WAIT_TIMEOUT_EN
    localparam int unsigned WW = $clog2(WAIT_TIMEOUT + 1);

    logic [WW-1:0] wcnt_q;
    logic          to_q;
    logic          wait_end;

    // A wait-driven decision point: end of T2/TW with the mandatory I/O TW already paid.
    assign wait_end     = ((state_q == StT2) || (state_q == StTw)) && t_last && !owed_q &&
                          !WAIT_n;
    assign wait_expired = (wcnt_q >= WW'(WAIT_TIMEOUT));
    assign timed_out    = to_q;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wcnt_q <= '0;
            to_q   <= 1'b0;
        end else if (accept) begin
            wcnt_q <= '0;
            to_q   <= 1'b0;
        end else if (wait_end) begin
            if (wait_expired) begin
                to_q <= 1'b1;
            end else begin
                wcnt_q <= wcnt_q + 1'b1;
            end
        end
    end
`else
    logic unused_wait_timeout;

    assign wait_expired        = 1'b0;
    assign timed_out           = 1'b0;
    assign unused_wait_timeout = (WAIT_TIMEOUT == 0);
`endif

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= StIdle;
            tcnt_q  <= '0;
            wr_q    <= 1'b0;
            io_q    <= 1'b0;
            owed_q  <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'hFF;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            wr_q    <= wr_d;
            io_q    <= io_d;
            owed_q  <= owed_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        io_d    = io_q;
        owed_d  = owed_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        // Counter runs only inside T-states; leaving IDLE therefore always starts at zero.
        if ((state_q == StT1 || state_q == StT2 || state_q == StTw || state_q == StT3) &&
            !t_last) begin
            tcnt_d = tcnt_q + 1'b1;
        end else begin
            tcnt_d = '0;
        end

        case (state_q)
            StIdle: begin
                if (REQ) begin
                    state_d = StT1;
                    wr_d    = REQ_WR;
                    io_d    = REQ_IO;
                    owed_d  = REQ_IO;
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                end
            end
            StT1: begin
                if (t_last) begin
                    state_d = StT2;
                end
            end
            StT2, StTw: begin
                if (t_last) begin
                    if (owed_q) begin
                        state_d = StTw;
                        owed_d  = 1'b0;
                    end else if (!WAIT_n && !wait_expired) begin
                        state_d = StTw;
                    end else begin
                        state_d = StT3;
                    end
                end
            end
            StT3: begin
                if (t_last) begin
                    state_d = StDone;
                    if (!wr_q) begin
                        // Floating bus reads as FF: no I/O responder, or the wait was aborted.
                        rdata_d = (timed_out || (io_q && BUSDIR_n)) ? 8'hFF : DIN;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    logic early;
    logic active;

    assign early  = (state_q == StT1) && (tcnt_q >= T_HALF);
    assign active = (state_q == StT2) || (state_q == StTw) || (state_q == StT3);

    always_comb begin
        MERQ_n  = 1'b1;
        SLTSL_n = 1'b1;
        IORQ_n  = 1'b1;
        RD_n    = 1'b1;
        WR_n    = 1'b1;
        DOUT_OE = 1'b0;

        if (io_q) begin
            IORQ_n = !active;
            RD_n   = wr_q || !active;
            WR_n   = !(wr_q && active);
        end else begin
            MERQ_n  = !(early || active);
            SLTSL_n = !(early || active);
            RD_n    = wr_q || !(early || active);
            WR_n    = !(wr_q && active);
        end

        DOUT_OE = wr_q && ((state_q == StT1) || active);
    end

    assign ACK         = (state_q == StDone);
    assign TIMEOUT_ERR = (state_q == StDone) && timed_out;
    assign BUSY        = (state_q != StIdle);
    assign ADDR        = addr_q;
    assign DOUT        = wdata_q;
    assign RDATA       = rdata_q;

endmodule

// File: tb/tb_msx_bus_initiator.sv
// Directed bench for msx_bus_initiator (T_DIV=6, WAIT_TIMEOUT=4) with a scoreboard of
// expected ACK clock, read data and timeout flag per transaction.
module tb_msx_bus_initiator;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic        REQ, REQ_WR, REQ_IO;
    logic [15:0] REQ_ADDR;
    logic [7:0]  REQ_WDATA;
    logic        ACK;
    logic [7:0]  RDATA;
    logic        BUSY, TIMEOUT_ERR;
    logic [15:0] ADDR;
    logic [7:0]  DOUT;
    logic        DOUT_OE;
    logic [7:0]  DIN;
    logic        BUSDIR_n, WAIT_n;
    logic        MERQ_n, IORQ_n, RD_n, WR_n, SLTSL_n;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       to;
        int         ack;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    msx_bus_initiator #(
        .T_DIV        (6),
        .WAIT_TIMEOUT (4)
    ) dut (
        .CLK         (CLK),
        .RESET_n     (RESET_n),
        .REQ         (REQ),
        .REQ_WR      (REQ_WR),
        .REQ_IO      (REQ_IO),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_WDATA   (REQ_WDATA),
        .ACK         (ACK),
        .RDATA       (RDATA),
        .BUSY        (BUSY),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .ADDR        (ADDR),
        .DOUT        (DOUT),
        .DOUT_OE     (DOUT_OE),
        .DIN         (DIN),
        .BUSDIR_n    (BUSDIR_n),
        .WAIT_n      (WAIT_n),
        .MERQ_n      (MERQ_n),
        .IORQ_n      (IORQ_n),
        .RD_n        (RD_n),
        .WR_n        (WR_n),
        .SLTSL_n     (SLTSL_n)
    );

    function automatic logic [5:0] bus_vec();
        return {MERQ_n, SLTSL_n, RD_n, WR_n, IORQ_n, DOUT_OE};
    endfunction

    // Reference bus waveform with T_DIV=6: clock k counted from 1 after the accept edge.
    function automatic logic [5:0] exp_bus(input logic wr, input logic io, input int k,
                                           input int ack);
        logic in_t, mlow, iolow, strobe;
        in_t   = (k < ack);
        mlow   = !io && (k >= 4) && in_t;
        iolow  = io && (k >= 7) && in_t;
        strobe = io ? iolow : mlow;
        return {!mlow, !mlow, !(!wr && strobe), !(wr && (k >= 7) && in_t), !iolow,
                wr && in_t};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic wr, input logic io, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [7:0] din, input logic bd,
                           input int wl, input int exp_ack, input logic [7:0] exp_rdata,
                           input logic exp_to);
        exp_t e;
        int   k;
        logic got;
        e.rdata = exp_rdata;
        e.to    = exp_to;
        e.ack   = exp_ack;
        sb.push_back(e);

        @(negedge CLK);
        REQ_WR    = wr;
        REQ_IO    = io;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        DIN       = din;
        BUSDIR_n  = bd;
        REQ       = 1'b1;
        @(posedge CLK);
        #1;
        REQ       = 1'b0;
        REQ_ADDR  = ~addr;
        REQ_WDATA = ~wdata;
        k   = 1;
        got = 1'b0;
        while (!got && k <= exp_ack + 20) begin
            WAIT_n = (k < wl) ? 1'b0 : 1'b1;
            if (k == 1) begin
                check("addr", 32'(ADDR), 32'(addr));
                if (wr) check("dout", 32'(DOUT), 32'(wdata));
            end
            check("bus", 32'(bus_vec()), 32'(exp_bus(wr, io, k, exp_ack)));
            check("busy", 32'(BUSY), 32'd1);
            if (ACK === 1'b1) begin
                got = 1'b1;
                e   = sb.pop_front();
                check("ack_clock", 32'(k), 32'(e.ack));
                check("rdata", 32'(RDATA), 32'(e.rdata));
                check("timeout_err", 32'(TIMEOUT_ERR), 32'(e.to));
            end else begin
                @(posedge CLK);
                #1;
                k++;
            end
        end
        if (!got) begin
            check("ack_seen", 32'(got), 32'd1);
            void'(sb.pop_front());
        end
        WAIT_n = 1'b1;
        @(posedge CLK);
        #1;
        check("busy_drop", 32'(BUSY), 32'd0);
        check("ack_pulse", 32'(ACK), 32'd0);
        check("rdata_hold", 32'(RDATA), 32'(exp_rdata));
    endtask

    initial begin
        int acks;
        RESET_n   = 1'b0;
        REQ       = 1'b0;
        REQ_WR    = 1'b0;
        REQ_IO    = 1'b0;
        REQ_ADDR  = 16'h0000;
        REQ_WDATA = 8'h00;
        DIN       = 8'h00;
        BUSDIR_n  = 1'b1;
        WAIT_n    = 1'b1;
        #23;
        check("rst_bus", 32'(bus_vec()), 32'b111110);
        check("rst_addr", 32'(ADDR), 32'h0);
        check("rst_dout", 32'(DOUT), 32'h0);
        check("rst_ack_busy_to", 32'({ACK, BUSY, TIMEOUT_ERR}), 32'b000);
        check("rst_rdata", 32'(RDATA), 32'hFF);
        @(negedge CLK);
        RESET_n = 1'b1;

        run_txn(1'b0, 1'b0, 16'h4000, 8'h00, 8'h5A, 1'b1, 0, 19, 8'h5A, 1'b0);
        run_txn(1'b1, 1'b0, 16'h8000, 8'hC3, 8'hEE, 1'b1, 0, 19, 8'h5A, 1'b0);
        run_txn(1'b0, 1'b1, 16'h0098, 8'h00, 8'h12, 1'b0, 0, 25, 8'h12, 1'b0);
        run_txn(1'b0, 1'b1, 16'h0098, 8'h00, 8'h34, 1'b1, 0, 25, 8'hFF, 1'b0);
        run_txn(1'b1, 1'b1, 16'h1299, 8'h40, 8'h00, 1'b1, 0, 25, 8'hFF, 1'b0);
        run_txn(1'b0, 1'b0, 16'h4123, 8'h00, 8'hA5, 1'b1, 30, 37, 8'hA5, 1'b0);
`ifdef MSX_BUS_INITIATOR_WAIT_TIMEOUT_EN
        run_txn(1'b0, 1'b0, 16'h6000, 8'h00, 8'h77, 1'b1, 1000, 43, 8'hFF, 1'b1);
`endif

        // Reset pulse during T2 of a memory write.
        @(negedge CLK);
        REQ_WR    = 1'b1;
        REQ_IO    = 1'b0;
        REQ_ADDR  = 16'h8001;
        REQ_WDATA = 8'h99;
        REQ       = 1'b1;
        @(posedge CLK);
        #1;
        REQ = 1'b0;
        repeat (8) @(posedge CLK);
        #2;
        check("mid_wr_low", 32'({WR_n, MERQ_n, DOUT_OE}), 32'b001);
        RESET_n = 1'b0;
        #1;
        check("mid_rst_bus", 32'(bus_vec()), 32'b111110);
        check("mid_rst_busy_ack", 32'({BUSY, ACK}), 32'b00);
        check("mid_rst_rdata", 32'(RDATA), 32'hFF);
        @(negedge CLK);
        RESET_n = 1'b1;
        acks = 0;
        repeat (30) begin
            @(posedge CLK);
            #1;
            if (ACK === 1'b1) acks++;
        end
        check("mid_rst_no_ack", 32'(acks), 32'd0);

        run_txn(1'b0, 1'b0, 16'h4001, 8'h00, 8'h3C, 1'b1, 0, 19, 8'h3C, 1'b0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
